// File: rtl/mmio_pwm_led_pkg.sv
// Shared definitions for the memory-mapped PWM LED controller.
// Optional build macro: PWM_IRQ_EN (period-wrap status flag and irq output).
package mmio_pwm_led_pkg;

    // Register byte offsets inside the 4 KiB window
    localparam logic [11:0] PWM_CTRL_OFF      = 12'h000;
    localparam logic [11:0] PWM_PERIOD_OFF    = 12'h004;
    localparam logic [11:0] PWM_STATUS_OFF    = 12'h008;
    localparam logic [11:0] PWM_DUTY_BASE_OFF = 12'h010;

    // CTRL field positions
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_PRESC_LSB = 8;

    // STATUS field positions
    localparam int STATUS_WRAP_BIT = 0;

    // Byte offset of the duty register belonging to channel ch
    function automatic logic [11:0] duty_offset(input int ch);
        return PWM_DUTY_BASE_OFF + 12'(4 * ch);
    endfunction

endpackage

// File: rtl/mmio_pwm_led_timebase.sv
// Shared PWM timebase: prescaler, period counter and wrap detection.
// The counter compares against the shadowed period so that period changes
// only take effect at a frame boundary.
module pwm_timebase #(
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic [CNT_W-1:0]   period,
    output logic [CNT_W-1:0]   cnt,
    output logic               wrap
);

    logic [PRESC_W-1:0] pre_cnt;
    logic               tick;

    assign tick = en && (pre_cnt == presc);
    assign wrap = tick && (cnt == period);

    // Prescaler: counts 0..presc, restarts on each tick, held at 0 while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (!en || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRESC_W'(1);
        end
    end

    // Period counter: advances on tick, wraps to 0 after reaching period
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || wrap) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mmio_pwm_led.sv
// Memory-mapped multi-channel PWM controller for board LEDs.
// Holds the register file, double-buffered duty/period shadows and the
// per-channel comparators; the timebase lives in pwm_timebase.
// Optional build macro: PWM_IRQ_EN adds the STATUS.WRAP flag and drives irq.
module mmio_pwm_led
    import mmio_pwm_led_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 8,
    parameter int          PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              sel,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    logic [11:0]        offset;
    logic               aligned;
    logic               wr_hit;

    logic               ctrl_en;
    logic [PRESC_W-1:0] ctrl_presc;
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W-1:0]   duty_reg    [NUM_CH];

    logic [CNT_W-1:0]   shadow_period;
    logic [CNT_W-1:0]   shadow_duty [NUM_CH];

    logic [CNT_W-1:0]   cnt;
    logic               wrap;
    logic [31:0]        rd_next;

    logic               unused_wr_bits;

    assign offset  = addr[11:0];
    assign aligned = (addr[1:0] == 2'b00);
    assign sel     = (addr[31:12] == BASE_ADDR[31:12]);
    assign wr_hit  = wr_en && sel && aligned;

    assign unused_wr_bits = ^wr_data;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk    (clk),
        .reset  (reset),
        .en     (ctrl_en),
        .presc  (ctrl_presc),
        .period (shadow_period),
        .cnt    (cnt),
        .wrap   (wrap)
    );

    // Register file writes: aligned word writes to mapped offsets only
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en    <= 1'b0;
            ctrl_presc <= '0;
            period_reg <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_reg[i] <= '0;
            end
        end else if (wr_hit) begin
            case (offset)
                PWM_CTRL_OFF: begin
                    ctrl_en    <= wr_data[CTRL_EN_BIT];
                    ctrl_presc <= wr_data[CTRL_PRESC_LSB +: PRESC_W];
                end
                PWM_PERIOD_OFF: begin
                    period_reg <= wr_data[CNT_W-1:0];
                end
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (offset == duty_offset(i)) begin
                            duty_reg[i] <= wr_data[CNT_W-1:0];
                        end
                    end
                end
            endcase
        end
    end

    // Shadows follow the registers while idle and reload only at a frame wrap,
    // so a write landing on the wrap edge is seen one frame later
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_period <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_duty[i] <= '0;
            end
        end else if (!ctrl_en || wrap) begin
            shadow_period <= period_reg;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_duty[i] <= duty_reg[i];
            end
        end
    end

    // Per-channel comparators, registered for glitch-free LED drive
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_out[i] <= ctrl_en && (cnt < shadow_duty[i]);
            end
        end
    end

`ifdef PWM_IRQ_EN
    logic wrap_flag;

    // Sticky wrap flag; a new wrap beats a simultaneous write-1-to-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_flag <= 1'b0;
        end else if (wrap) begin
            wrap_flag <= 1'b1;
        end else if (wr_hit && (offset == PWM_STATUS_OFF) && wr_data[STATUS_WRAP_BIT]) begin
            wrap_flag <= 1'b0;
        end
    end

    assign irq = wrap_flag;
`else
    assign irq = 1'b0;
`endif

    // Read mux: unmapped, misaligned or out-of-window reads return 0
    always_comb begin
        rd_next = '0;
        if (sel && aligned) begin
            case (offset)
                PWM_CTRL_OFF: begin
                    rd_next[CTRL_EN_BIT]                = ctrl_en;
                    rd_next[CTRL_PRESC_LSB +: PRESC_W]  = ctrl_presc;
                end
                PWM_PERIOD_OFF: begin
                    rd_next[CNT_W-1:0] = period_reg;
                end
                PWM_STATUS_OFF: begin
`ifdef PWM_IRQ_EN
                    rd_next[STATUS_WRAP_BIT] = wrap_flag;
`else
                    rd_next = '0;
`endif
                end
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (offset == duty_offset(i)) begin
                            rd_next[CNT_W-1:0] = duty_reg[i];
                        end
                    end
                end
            endcase
        end
    end

    // Registered read data, one cycle after the address is presented
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_mmio_pwm_led.sv
// Directed self-checking bench for mmio_pwm_led (default parameters).
// Optional build macro: PWM_IRQ_EN selects the irq/STATUS checks.
module tb_mmio_pwm_led;

    localparam logic [31:0] BASE = 32'h0000_F000;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        sel;
    logic [3:0]  pwm_out;
    logic        irq;

    int n_compared;
    int n_mismatched;

    logic [31:0]       rv;
    logic [3:0][63:0]  bits;

    mmio_pwm_led dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .sel     (sel),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point with immediate assertion
    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle write strobe; returns on the falling edge after the write edge
    task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    // Present an address and pick up the registered read data one cycle later
    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        @(negedge clk);
        d = rd_data;
    endtask

    // Sample all pwm channels on n falling edges, optionally writing mid-run
    task automatic apply_stimulus(input int n, input int wr_at, input logic [31:0] wa,
                                  input logic [31:0] wd, output logic [3:0][63:0] b);
        b = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) b[c][i] = pwm_out[c];
            if (i == wr_at) begin
                wr_en   = 1'b1;
                addr    = wa;
                wr_data = wd;
            end else if (i == wr_at + 1) begin
                wr_en   = 1'b0;
                wr_data = '0;
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset   = 1'b1;
        wr_en   = 1'b0;
        addr    = BASE;
        wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_output("reset_pwm", 64'(pwm_out), 64'h0);
        check_output("reset_irq", 64'(irq), 64'h0);
        check_output("reset_rd", 64'(rd_data), 64'h0);
        read_reg(BASE + 32'h00, rv); check_output("reset_ctrl", 64'(rv), 64'h0);
        read_reg(BASE + 32'h04, rv); check_output("reset_period", 64'(rv), 64'h0);
        read_reg(BASE + 32'h08, rv); check_output("reset_status", 64'(rv), 64'h0);
        read_reg(BASE + 32'h10, rv); check_output("reset_duty0", 64'(rv), 64'h0);
        read_reg(BASE + 32'h1C, rv); check_output("reset_duty3", 64'(rv), 64'h0);

        // Address window decode
        addr = BASE; #1;
        check_output("sel_base", 64'(sel), 64'h1);
        addr = BASE + 32'hFFC; #1;
        check_output("sel_top", 64'(sel), 64'h1);
        addr = BASE + 32'h1000; #1;
        check_output("sel_above", 64'(sel), 64'h0);
        addr = BASE - 32'h4; #1;
        check_output("sel_below", 64'(sel), 64'h0);

        // Period 10, duties 3/3/0/255; DUTY1 rewritten to 8 while cnt=5
        write_reg(BASE + 32'h04, 32'd9);
        write_reg(BASE + 32'h10, 32'd3);
        write_reg(BASE + 32'h14, 32'd3);
        write_reg(BASE + 32'h18, 32'd0);
        write_reg(BASE + 32'h1C, 32'd255);
        write_reg(BASE + 32'h00, 32'h1);
        apply_stimulus(20, 4, BASE + 32'h14, 32'd8, bits);
        check_output("duty3_wave", bits[0], 64'h01C07);
        check_output("duty_midframe", bits[1], 64'h3FC07);
        check_output("duty0_low", bits[2], 64'h0);
        check_output("duty255_high", bits[3], 64'hFFFFF);

        // PERIOD=0 with DUTY0=1 is constantly high
        write_reg(BASE + 32'h00, 32'h0);
        write_reg(BASE + 32'h04, 32'd0);
        write_reg(BASE + 32'h10, 32'd1);
        write_reg(BASE + 32'h00, 32'h1);
        apply_stimulus(10, -5, BASE, 32'h0, bits);
        check_output("period0_high", bits[0], 64'h3FF);

        // Prescaler 3, period 4 ticks, duty 2: 8 high of 16 cycles
        write_reg(BASE + 32'h00, 32'h0);
        write_reg(BASE + 32'h04, 32'd3);
        write_reg(BASE + 32'h10, 32'd2);
        write_reg(BASE + 32'h00, 32'h301);
        apply_stimulus(32, -5, BASE, 32'h0, bits);
        check_output("presc_wave", bits[0], 64'h00FF00FF);

        // Disable mid-frame, then re-enable from a fresh frame
        write_reg(BASE + 32'h00, 32'h0);
        write_reg(BASE + 32'h00, 32'h301);
        apply_stimulus(12, 5, BASE + 32'h00, 32'h300, bits);
        check_output("disable_midframe", bits[0], 64'h07F);
        write_reg(BASE + 32'h00, 32'h301);
        apply_stimulus(16, -5, BASE, 32'h0, bits);
        check_output("reenable_restart", bits[0], 64'h00FF);

        // Readback and access rules
        read_reg(BASE + 32'h00, rv); check_output("rd_ctrl", 64'(rv), 64'h301);
        read_reg(BASE + 32'h04, rv); check_output("rd_period", 64'(rv), 64'd3);
        read_reg(BASE + 32'h14, rv); check_output("rd_duty1", 64'(rv), 64'd8);
        read_reg(BASE + 32'h1C, rv); check_output("rd_duty3", 64'(rv), 64'd255);
        write_reg(BASE + 32'h05, 32'hAB);
        read_reg(BASE + 32'h04, rv); check_output("misaligned_wr", 64'(rv), 64'd3);
        read_reg(BASE + 32'h05, rv); check_output("misaligned_rd", 64'(rv), 64'h0);
        write_reg(BASE + 32'h0C, 32'h55);
        read_reg(BASE + 32'h0C, rv); check_output("unmapped_0c", 64'(rv), 64'h0);
        write_reg(BASE + 32'h20, 32'h66);
        read_reg(BASE + 32'h20, rv); check_output("unmapped_duty4", 64'(rv), 64'h0);
        read_reg(32'h0000_E000, rv); check_output("outside_window", 64'(rv), 64'h0);
        write_reg(BASE + 32'h18, 32'hFFFF_FFFF);
        read_reg(BASE + 32'h18, rv); check_output("upper_duty2", 64'(rv), 64'hFF);
        write_reg(BASE + 32'h00, 32'hFFFF_FFFF);
        read_reg(BASE + 32'h00, rv); check_output("upper_ctrl", 64'(rv), 64'hFF01);
        write_reg(BASE + 32'h00, 32'h0);

`ifdef PWM_IRQ_EN
        // Wrap flag: clear while idle, rise at first wrap, clear, set-wins
        write_reg(BASE + 32'h08, 32'h1);
        check_output("irq_cleared", 64'(irq), 64'h0);
        write_reg(BASE + 32'h04, 32'd9);
        write_reg(BASE + 32'h00, 32'h1);
        repeat (9) @(negedge clk);
        check_output("irq_before_wrap", 64'(irq), 64'h0);
        @(negedge clk);
        check_output("irq_first_wrap", 64'(irq), 64'h1);
        write_reg(BASE + 32'h08, 32'h1);
        check_output("irq_w1c", 64'(irq), 64'h0);
        write_reg(BASE + 32'h04, 32'd0);
        repeat (15) @(negedge clk);
        write_reg(BASE + 32'h08, 32'h1);
        check_output("irq_set_wins", 64'(irq), 64'h1);
        read_reg(BASE + 32'h08, rv); check_output("status_wrap", 64'(rv), 64'h1);
`else
        // Without the wrap flag, irq and STATUS stay 0 after many wraps
        write_reg(BASE + 32'h08, 32'h1);
        read_reg(BASE + 32'h08, rv); check_output("status_zero", 64'(rv), 64'h0);
        check_output("irq_tied_low", 64'(irq), 64'h0);
`endif

        // Reset in the middle of a running frame
        write_reg(BASE + 32'h00, 32'h1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("midframe_reset_pwm", 64'(pwm_out), 64'h0);
        check_output("midframe_reset_irq", 64'(irq), 64'h0);
        reset = 1'b0;
        read_reg(BASE + 32'h00, rv); check_output("midframe_reset_ctrl", 64'(rv), 64'h0);
        read_reg(BASE + 32'h10, rv); check_output("midframe_reset_duty0", 64'(rv), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
